// File: rtl/camera64x64_pkg.sv
// rtl/camera64x64_pkg.sv - shared controller states and default timing constants
package camera64x64_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_WAIT_INT = 2'd2,
    ST_RELEASE  = 2'd3
  } cam_state_t;

  // SCLK half-period in CLK cycles
  localparam int unsigned DEF_HALF = 2;

  // 150000 cycles = 1.5 ms at 100 MHz
  localparam logic [31:0] DEF_TIMEOUT = 32'h000249F0;

endpackage

// File: rtl/camera64x64_counter.sv
// rtl/camera64x64_counter.sv - generic saturating up-counter with synchronous clear
module camera64x64_counter #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // Count up while enabled, hold at all-ones instead of wrapping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/camera_spi_shifter.sv
// rtl/camera_spi_shifter.sv - SPI mode 0 byte shifter, MSB first
module camera_spi_shifter #(
  parameter int unsigned HALF = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       sclk,
  output logic       mosi
);

  localparam logic [7:0] HALF_LAST = 8'(HALF - 1);

  logic       active;
  logic       phase;     // 0 = SCLK low half, 1 = SCLK high half
  logic [7:0] half_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sreg;
  logic       half_end;

  assign half_end = active && (half_cnt == HALF_LAST);
  // Last cycle of the high half of bit 0: the byte is complete
  assign done     = half_end && phase && (bit_cnt == 3'd7);
  assign sclk     = active && phase;
  // Shift-out drains to zero, so MOSI idles low after the byte
  assign mosi     = sreg[7];

  // Half-period divider, bit counter and shift register; data advances on SCLK fall
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active   <= 1'b0;
      phase    <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      sreg     <= '0;
    end else if (!active) begin
      if (start) begin
        active   <= 1'b1;
        phase    <= 1'b0;
        half_cnt <= '0;
        bit_cnt  <= '0;
        sreg     <= data;
      end
    end else if (half_end) begin
      half_cnt <= '0;
      phase    <= ~phase;
      if (phase) begin
        sreg    <= {sreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          active <= 1'b0;
        end
      end
    end else begin
      half_cnt <= half_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/camera64x64_host_ctrl.sv
// rtl/camera64x64_host_ctrl.sv - camera lookup command issuer with INT wait and timeout
module camera64x64_host_ctrl
  import camera64x64_pkg::*;
#(
  parameter int unsigned HALF    = DEF_HALF,
  parameter logic [31:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] CMD,
  input  logic       INT,
  input  logic       LOOKUP,
  output logic       SCLK,
  output logic       MOSI,
  output logic       CS_N,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [31:0] WAIT_LAST = TIMEOUT - 32'd1;

  cam_state_t  state;
  cam_state_t  state_nxt;
  logic        shift_start;
  logic        shift_done;
  logic        wait_en;
  logic [31:0] wait_cnt;

  // The shifter loads CMD on the accepting edge, so MOSI carries bit 7 in the first SHIFT cycle
  camera_spi_shifter #(
    .HALF (HALF)
  ) u_shifter (
    .CLK   (CLK),
    .RST   (RST),
    .start (shift_start),
    .data  (CMD),
    .done  (shift_done),
    .sclk  (SCLK),
    .mosi  (MOSI)
  );

  assign wait_en = (state == ST_WAIT_INT);

  // Held at zero outside WAIT_INT so it reads 0 in the first wait cycle
  camera64x64_counter #(
    .W (32)
  ) u_wait_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (!wait_en),
    .en  (wait_en),
    .q   (wait_cnt)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs; INT takes priority over the terminal count
  always_comb begin
    state_nxt   = state;
    shift_start = 1'b0;
    BUSY        = 1'b1;
    CS_N        = 1'b0;
    DONE        = 1'b0;
    ERR         = 1'b0;
    case (state)
      ST_IDLE: begin
        BUSY = 1'b0;
        CS_N = 1'b1;
        if (START) begin
          shift_start = 1'b1;
          state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_done) begin
          state_nxt = ST_WAIT_INT;
        end
      end
      ST_WAIT_INT: begin
        if (INT) begin
          DONE      = 1'b1;
          state_nxt = ST_RELEASE;
        end else if (wait_cnt == WAIT_LAST) begin
          ERR       = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        CS_N = 1'b1;
        if (!INT && !LOOKUP) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_camera64x64_host_ctrl.sv
// tb/tb_camera64x64_host_ctrl.sv - scoreboard bench for camera64x64_host_ctrl
module tb_camera64x64_host_ctrl;

  localparam int TMO = 1000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [7:0] CMD = 8'h00;
  logic       INT = 1'b0;
  logic       LOOKUP = 1'b0;
  logic       SCLK, MOSI, CS_N, BUSY, DONE, ERR;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int cyc;
    bit is_done;
  } ev_t;

  logic mosi_q[$];
  ev_t  ev_q[$];

  camera64x64_host_ctrl #(
    .HALF    (2),
    .TIMEOUT (32'(TMO))
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .CMD    (CMD),
    .INT    (INT),
    .LOOKUP (LOOKUP),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .CS_N   (CS_N),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One transaction; cycle 0 is the first SHIFT cycle. Inputs change at posedge+1, outputs sampled at negedge.
  task automatic txn(input logic [7:0] c, input int int_at, input bit noise,
                     input bit restart, input int rst_at, input int ncyc);
    ev_t  ev;
    ev_t  got;
    int   evc = -1;
    int   idle_c = -1;
    logic prev_sclk = 1'b0;
    logic prev_mosi = 1'b0;
    int   bad_sclk = 0;
    int   bad_cs = 0;
    int   bad_mchg = 0;
    logic exp_sclk;

    for (int b = 7; b >= 0; b--) mosi_q.push_back(c[b]);
    if (rst_at < 0) begin
      if (int_at >= 32 && int_at <= 31 + TMO) begin
        ev.cyc = int_at;  ev.is_done = 1'b1;
        idle_c = int_at + 5;
      end else begin
        ev.cyc = 31 + TMO; ev.is_done = 1'b0;
        idle_c = 31 + TMO + 2;
      end
      evc = ev.cyc;
      ev_q.push_back(ev);
    end

    @(posedge CLK); #1;
    START = 1'b1; CMD = c;
    @(posedge CLK); #1;

    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) begin
        @(posedge CLK); #1;
      end
      START  = restart && (i == 5 || i == 40);
      CMD    = START ? 8'hFF : 8'h00;
      INT    = (i == int_at) || (noise && i == 3);
      LOOKUP = (int_at >= 0 && i >= int_at && i <= int_at + 3) || (noise && i >= 4 && i <= 6);
      if (i == rst_at + 1) RST = 1'b0;
      if (i == rst_at) begin
        #1; RST = 1'b1;
      end
      @(negedge CLK);

      if (i == 0 && rst_at != 0) chk("busy_cs_first_cycle", {BUSY, CS_N}, 2'b10);
      if (i == rst_at) begin
        chk("reset_mid_shift_outputs", {SCLK, MOSI, CS_N, BUSY, DONE, ERR}, 6'b001000);
        mosi_q.delete();
      end
      if (i < 32 && (rst_at < 0 || i < rst_at)) begin
        exp_sclk = ((i % 4) >= 2);
        if (SCLK !== exp_sclk) bad_sclk++;
      end
      if (rst_at < 0 && i <= evc && CS_N !== 1'b0) bad_cs++;
      if (i >= 1 && i <= 40 && (rst_at < 0 || i < rst_at) && MOSI !== prev_mosi && !(prev_sclk && !SCLK))
        bad_mchg++;
      if (SCLK && !prev_sclk) begin
        if (mosi_q.size() == 0) chk("unexpected_sclk_rise", i, 32'hFFFF_FFFF);
        else chk("mosi_bit", MOSI, mosi_q.pop_front());
      end
      if (DONE || ERR) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_done_err", {DONE, ERR}, 2'b00);
        end else begin
          got = ev_q.pop_front();
          chk("event_cycle", i, got.cyc);
          chk("event_done", DONE, got.is_done);
          chk("event_err", ERR, !got.is_done);
        end
      end
      if (evc >= 0 && i == evc + 1) chk("cs_high_in_release", CS_N, 1'b1);
      if (idle_c >= 0 && i == idle_c - 1) chk("busy_last_release", BUSY, 1'b1);
      if (idle_c >= 0 && i == idle_c) chk("idle_return", BUSY, 1'b0);
      prev_sclk = SCLK;
      prev_mosi = MOSI;
    end
    START = 1'b0; INT = 1'b0; LOOKUP = 1'b0; CMD = 8'h00;

    if (rst_at < 0) begin
      chk("sclk_pattern_errors", bad_sclk, 0);
      chk("cs_low_errors", bad_cs, 0);
    end
    chk("mosi_change_off_fall", bad_mchg, 0);
    chk("mosi_queue_drained", mosi_q.size(), 0);
    chk("event_queue_drained", ev_q.size(), 0);
    chk("busy_at_end", BUSY, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outputs", {SCLK, MOSI, CS_N, BUSY, DONE, ERR}, 6'b001000);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_after_reset", {SCLK, MOSI, CS_N, BUSY, DONE, ERR}, 6'b001000);

    // 0xA5 with INT/LOOKUP noise during SHIFT, INT well into the wait
    txn(8'hA5, 100, 1'b1, 1'b0, -1, 112);
    // START pulsed at SHIFT cycle 5 and during WAIT_INT must not restart
    txn(8'h3C, 100, 1'b0, 1'b1, -1, 112);
    // INT in the very first WAIT_INT cycle pins SHIFT to 32 cycles
    txn(8'h81, 32, 1'b0, 1'b0, -1, 45);
    // INT tied low: ERR at wait count TIMEOUT-1
    txn(8'h5A, -1, 1'b0, 1'b0, -1, 1040);
    // INT exactly at the terminal count: DONE wins
    txn(8'hC3, 31 + TMO, 1'b0, 1'b0, -1, 1040);
    // Reset in SHIFT cycle 10 aborts silently
    txn(8'hF0, -1, 1'b0, 1'b0, 10, 20);
    // Normal transaction after the abort
    txn(8'h69, 60, 1'b0, 1'b0, -1, 70);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/camera64x64_host_ctrl.md
CAMERA64X64_HOST_CTRL -- requirements
Module: camera64x64_host_ctrl

Interface
REQ-001 SHALL have parameter HALF, default 2, meaning SCLK half-period in CLK cycles (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 32'h000249F0 (150000 cycles = 1.5 ms at 100 MHz), meaning the maximum number of CLK cycles spent waiting for INT.
REQ-003 SHALL have port CLK  input  1  clock, 100 MHz; one clock only.
REQ-004 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port START  input  1  one-cycle request to issue a lookup command.
REQ-006 SHALL have port CMD  input  8  command byte, sampled in the cycle START is accepted.
REQ-007 SHALL have port INT  input  1  camera interrupt, synchronous to CLK.
REQ-008 SHALL have port LOOKUP  input  1  camera lookup status, synchronous to CLK.
REQ-009 SHALL have port SCLK  output  1  SPI clock, mode 0 (idle low).
REQ-010 SHALL have port MOSI  output  1  SPI data, MSB first.
REQ-011 SHALL have port CS_N  output  1  SPI chip select, active low.
REQ-012 SHALL have port BUSY  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse when INT is received.
REQ-014 SHALL have port ERR  output  1  one-cycle pulse when the INT wait times out.

Function
REQ-015 SHALL implement four states: IDLE, SHIFT, WAIT_INT, RELEASE.
REQ-016 In IDLE, START=1 SHALL latch CMD and enter SHIFT on the next edge; BUSY and CS_N=0 SHALL appear in that same cycle.
REQ-017 START SHALL be ignored whenever BUSY=1; there is no queuing.
REQ-018 In SHIFT, MOSI SHALL present bit 7 from the first SHIFT cycle onward.
REQ-019 In SHIFT, each bit SHALL be HALF cycles with SCLK=0 followed by HALF cycles with SCLK=1.
REQ-020 MOSI SHALL change only at the SCLK high-to-low transition.
REQ-021 SHIFT SHALL last exactly 16*HALF cycles and produce exactly 8 SCLK rising edges, after which SCLK returns low and the state becomes WAIT_INT.
REQ-022 In WAIT_INT, CS_N SHALL stay 0, SCLK SHALL stay 0, and a 32-bit wait counter SHALL start at 0 and increment once per cycle.
REQ-023 In WAIT_INT, INT=1 SHALL assert DONE for one cycle and move to RELEASE.
REQ-024 In WAIT_INT, if the wait counter reaches TIMEOUT-1 with INT=0, ERR SHALL assert for one cycle and the state SHALL move to RELEASE.
REQ-025 If INT=1 in the terminal-count cycle, DONE SHALL win and ERR SHALL NOT assert.
REQ-026 INT or LOOKUP activity during IDLE or SHIFT SHALL be ignored.
REQ-027 In RELEASE, CS_N SHALL be 1 and the state SHALL stay for at least one cycle, returning to IDLE in the first cycle where INT=0 and LOOKUP=0.
REQ-028 DONE and ERR SHALL never assert in the same cycle and SHALL never assert outside the WAIT_INT-to-RELEASE transition.
REQ-029 The wait counter SHALL saturate and SHALL never wrap.

Reset
REQ-030 RST=1 SHALL immediately force state IDLE, SCLK=0, MOSI=0, CS_N=1, BUSY=0, DONE=0, ERR=0, and clear all counters and the command register.
REQ-031 Reset asserted mid-SHIFT or mid-WAIT_INT SHALL abort the transaction without emitting DONE or ERR.
REQ-032 After RST deasserts, the first START SHALL be accepted normally.

Structure
REQ-033 The state encoding and the default TIMEOUT and HALF constants SHALL live in the shared camera64x64 package.
REQ-034 The SCLK/MOSI bit engine (HALF divider, bit counter, shift register) SHALL be one sub-module, camera_spi_shifter, with start/done handshake.
REQ-035 The INT wait counter SHALL be built from the team's existing generic counter block.

Verification
REQ-036 HALF=2, CMD=0xA5, START pulse -> MOSI 1,0,1,0,0,1,0,1 at 8 SCLK rising edges; SHIFT lasts 32 cycles; CS_N low throughout.
REQ-037 Connected to the camera dummy model, TIMEOUT=150000 -> DONE pulses about 100000 cycles after the last SCLK edge; ERR stays 0; return to IDLE after LOOKUP falls.
REQ-038 INT tied 0, TIMEOUT=1000 -> ERR pulses in WAIT_INT cycle 1000; DONE stays 0; next cycle CS_N=1.
REQ-039 INT forced 1 exactly at wait count 999 with TIMEOUT=1000 -> DONE=1 and ERR=0.
REQ-040 START pulsed in cycle 5 of SHIFT and in WAIT_INT -> no restart; bit sequence and timing are unchanged.
REQ-041 RST asserted in cycle 10 of SHIFT -> outputs take reset values in the same cycle; no DONE/ERR; a new START after release completes normally.
